gc_sequencer: RTL and testbench
===============================

# gc_sequencer

Clocked controller that sequences the genetic sensor/filter instance (`gc_imp`). It drives the `Start` and `Sensor` stimulus lines through the fixed ten-step exercise sequence and waits on the `Actuator` response at each handshake point. Each wait is bounded by a timeout, completed sequences are counted, and the step at which a response failed is reported. It sits between a host/test controller and `gc_imp`, and replaces hand-written delay/wait stimulus with a synthesizable, self-checking scheduler.

## Interface
Parameters:
- DELAY, 5, cycles per stimulus step (≥1)
- TIMEOUT, 255, max cycles waited for an Actuator level (≥1)
- CNT_W, 8, width of completed-sequence counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- go  in  1  start request, sampled in IDLE only
- loop  in  1  sampled at end of sequence: 1 = restart, 0 = finish
- abort  in  1  force stop
- Actuator  in  1  response from gc_imp, asynchronous to clk
- Start  out  1  stimulus to gc_imp
- Sensor  out  1  stimulus to gc_imp
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on normal completion
- err  out  1  sticky timeout flag
- err_step  out  3  wait step that timed out (0 = none)
- cycles  out  CNT_W  completed sequences, saturating

## Operation
- Actuator passes through a 2-flop synchronizer; act_s is the synchronized value, 2-cycle latency.
- States in order: IDLE, D_SENS1 (Sensor←1), D_START1 (Start←1), W_HI1, D_SENS0 (Sensor←0), W_LO1, D_SENS2 (Sensor←1), W_HI2, D_START0 (Start←0), D_SENS3 (Sensor←0), W_LO2.
- IDLE with go=1: clear err, err_step and cycles; enter D_SENS1.
- D_* states: a timer starts at 0 on entry. When timer==DELAY-1, the named output takes its new value on the next edge and the FSM advances. Each D step lasts exactly DELAY cycles.
- W_HIn / W_LOn: advance the cycle after act_s==1 (HI) or act_s==0 (LO). If timer reaches TIMEOUT-1 without a match, timeout. err_step codes: W_HI1=1, W_LO1=2, W_HI2=3, W_LO2=4.
- Timeout: next edge Start=0, Sensor=0, err=1, err_step=code, FSM→IDLE, busy=0, no done pulse.
- End of W_LO2 match: cycles+1, saturating at 2^CNT_W−1. If loop=1, enter D_SENS1 with no done pulse. Else done=1 for one cycle and FSM→IDLE.
- abort=1 in any non-IDLE state: next edge Start=0, Sensor=0, FSM→IDLE, no done pulse, err/cycles unchanged. abort in IDLE has no effect.
- Priority: rst > abort > timeout > act match > timer step. go while busy is ignored.
- err, err_step and cycles hold in IDLE until the next accepted go.

## Timing
- Reset values (next edge after rst=1): state IDLE, Start=0, Sensor=0, busy=0, done=0, err=0, err_step=0, cycles=0, synchronizer flops=0, timer=0.
- Reset mid-sequence: all of the above on the next edge. Stimulus drops in the same cycle as abort would drop it.
- go accepted at edge N: busy=1 from N+1. Sensor rises at edge N+DELAY. Start rises at edge N+2·DELAY.
- Minimum wait-state dwell: 1 cycle, when act_s already matches on entry. Response latency from an Actuator edge to advance is 3 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- done and the final Sensor→0 → IDLE transition occur on the same edge as the last W_LO2 advance.
- Timer is TIMEOUT-wide enough (⌈log2(max(DELAY,TIMEOUT))⌉ bits) and resets on every state change.

## Test plan
- Nominal: DELAY=5, behavioral gc model responds 4 cycles after each stimulus, go pulse → Sensor↑ at +5, Start↑ at +10, full ten-step trace correct, done pulse once, cycles=1, err=0.
- Loop: loop=1 for two sequences then 0 → no done until end of third, cycles=3, Start/Sensor never both glitch low between sequences except per step order.
- Timeout: Actuator stuck at 1 after W_HI1, TIMEOUT=20 → 20 cycles in W_LO1, then err=1, err_step=2, Start=Sensor=0, busy=0, no done; next go clears err.
- Abort: abort asserted during D_SENS2 → next edge Start=Sensor=0, IDLE, cycles unchanged; abort coincident with timeout → err stays 0.
- Reset mid-run: rst pulse in W_HI2 → all outputs reset values next edge; go accepted during busy has no effect.
- Saturation: CNT_W=2, loop=1 for 5 sequences → cycles sticks at 3.

Source files
------------

// File: rtl/gc_sequencer_if.sv
// Host/gc_imp-facing signal bundle for gc_sequencer; the sequencer takes the slave side.
interface gc_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             go;
    logic             loop;
    logic             abort;
    logic             Actuator;
    logic             Start;
    logic             Sensor;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       err_step;
    logic [CNT_W-1:0] cycles;

    modport master (
        output go, loop, abort, Actuator,
        input  Start, Sensor, busy, done, err, err_step, cycles
    );

    modport slave (
        input  go, loop, abort, Actuator,
        output Start, Sensor, busy, done, err, err_step, cycles
    );
endinterface

// File: rtl/gc_sequencer.sv
// Drives gc_imp through the ten-step Start/Sensor exercise, waiting (bounded) on Actuator at each handshake.
// All outputs registered; Actuator reaches the FSM through a 2-flop synchronizer (3-cycle response latency).
module gc_sequencer #(
    parameter int DELAY   = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    gc_sequencer_if.slave bus
);
    localparam int TMAX = (DELAY > TIMEOUT) ? DELAY : TIMEOUT;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]    DLY_LAST = TW'(DELAY - 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [3:0] {
        IDLE, D_SENS1, D_START1, W_HI1, D_SENS0, W_LO1,
        D_SENS2, W_HI2, D_START0, D_SENS3, W_LO2
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             sync1_q, act_s_q;
    logic             start_q, start_d;
    logic             sensor_q, sensor_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [2:0]       err_step_q, err_step_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic       is_delay, is_wait, want_hi, act_match;
    logic [2:0] wait_code;

    always_comb begin
        is_delay  = 1'b0;
        is_wait   = 1'b0;
        want_hi   = 1'b0;
        wait_code = 3'd0;
        case (state_q)
            D_SENS1, D_START1, D_SENS0,
            D_SENS2, D_START0, D_SENS3: is_delay = 1'b1;
            W_HI1: begin is_wait = 1'b1; want_hi = 1'b1; wait_code = 3'd1; end
            W_LO1: begin is_wait = 1'b1; want_hi = 1'b0; wait_code = 3'd2; end
            W_HI2: begin is_wait = 1'b1; want_hi = 1'b1; wait_code = 3'd3; end
            W_LO2: begin is_wait = 1'b1; want_hi = 1'b0; wait_code = 3'd4; end
            default: ;
        endcase
        act_match = want_hi ? act_s_q : ~act_s_q;
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 1'b1;
        start_d    = start_q;
        sensor_d   = sensor_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_step_d = err_step_q;
        cycles_d   = cycles_q;

        if (state_q == IDLE) begin
            timer_d = '0;
            if (bus.go) begin
                err_d      = 1'b0;
                err_step_d = 3'd0;
                cycles_d   = '0;
                state_d    = D_SENS1;
            end
        end else if (bus.abort) begin
            state_d  = IDLE;
            start_d  = 1'b0;
            sensor_d = 1'b0;
        end else if (is_wait && timer_q == TMO_LAST) begin
            // a match arriving in the last allowed cycle still counts as a timeout
            state_d    = IDLE;
            start_d    = 1'b0;
            sensor_d   = 1'b0;
            err_d      = 1'b1;
            err_step_d = wait_code;
        end else if (is_wait && act_match) begin
            case (state_q)
                W_HI1:   state_d = D_SENS0;
                W_LO1:   state_d = D_SENS2;
                W_HI2:   state_d = D_START0;
                default: begin
                    if (cycles_q != CNT_MAX) cycles_d = cycles_q + 1'b1;
                    if (bus.loop) begin
                        state_d = D_SENS1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end else if (is_delay && timer_q == DLY_LAST) begin
            case (state_q)
                D_SENS1:  begin sensor_d = 1'b1; state_d = D_START1; end
                D_START1: begin start_d  = 1'b1; state_d = W_HI1;    end
                D_SENS0:  begin sensor_d = 1'b0; state_d = W_LO1;    end
                D_SENS2:  begin sensor_d = 1'b1; state_d = W_HI2;    end
                D_START0: begin start_d  = 1'b0; state_d = D_SENS3;  end
                default:  begin sensor_d = 1'b0; state_d = W_LO2;    end
            endcase
        end

        if (state_d != state_q) timer_d = '0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            sync1_q    <= 1'b0;
            act_s_q    <= 1'b0;
            start_q    <= 1'b0;
            sensor_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_step_q <= 3'd0;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sync1_q    <= bus.Actuator;
            act_s_q    <= sync1_q;
            start_q    <= start_d;
            sensor_q   <= sensor_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_step_q <= err_step_d;
            cycles_q   <= cycles_d;
        end
    end

    assign bus.Start    = start_q;
    assign bus.Sensor   = sensor_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_step = err_step_q;
    assign bus.cycles   = cycles_q;
endmodule

// File: tb/tb_gc_sequencer.sv
// Bench for gc_sequencer: a delayed-echo gc model plus a timeline model of the expected Start/Sensor/busy/done trace.
module tb_gc_sequencer;
    localparam int DLY  = 5;
    localparam int TMO  = 20;
    localparam int CW   = 2;
    localparam int MAXT = 1024;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    gc_sequencer_if #(.CNT_W(CW)) bus ();
    gc_sequencer #(.DELAY(DLY), .TIMEOUT(TMO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // gc model: Actuator echoes Start&Sensor L cycles later, or is held at a stuck level
    int          act_lat   = 0;
    bit          act_stuck = 1'b0;
    bit          act_val   = 1'b0;
    logic [15:0] p_sh      = '0;

    initial begin
        bus.Actuator = 1'b0;
        forever begin
            @(negedge clk);
            p_sh = {p_sh[14:0], bus.Start & bus.Sensor};
            bus.Actuator = act_stuck ? act_val : p_sh[act_lat];
        end
    end

    // Expected trace, indexed by offset from the edge that accepts go
    bit e_st[MAXT], e_se[MAXT], e_bz[MAXT], e_dn[MAXT];
    int m_t, m_end;
    bit m_st, m_se;
    int seq_end[$];
    int wentry[5], wexit[5];

    task automatic m_set(input int t, input bit st, input bit se);
        for (int i = m_t; i < t && i < MAXT; i++) begin
            e_st[i] = m_st; e_se[i] = m_se; e_bz[i] = 1'b1; e_dn[i] = 1'b0;
        end
        m_t = t; m_st = st; m_se = se;
    endtask

    // A stimulus change at edge s is echoed L cycles later, is seen by the FSM two edges after that,
    // and moves it one edge later; the dwell is never shorter than one cycle.
    task automatic do_wait(input int w, input int stim, input int L, input int tmo,
                           inout int t, inout bit fin);
        wentry[w] = t;
        if (tmo == w) begin
            t   = t + TMO;
            fin = 1'b1;
        end else begin
            t = (t + 1 > stim + L + 3) ? t + 1 : stim + L + 3;
        end
        wexit[w] = t;
    endtask

    task automatic build(input int L, input int nseq, input int tmo_step);
        int t, stim;
        bit fin;
        m_t = 0; m_st = 1'b0; m_se = 1'b0; t = 0; fin = 1'b0;
        seq_end.delete();
        act_lat = L;
        for (int s = 0; s < nseq; s++) begin
            t += DLY; m_set(t, 1'b0, 1'b1);
            t += DLY; m_set(t, 1'b1, 1'b1);
            do_wait(1, t, L, tmo_step, t, fin);
            if (fin) break;
            t += DLY; m_set(t, 1'b1, 1'b0);
            do_wait(2, t, L, tmo_step, t, fin);
            if (fin) break;
            t += DLY; m_set(t, 1'b1, 1'b1);
            do_wait(3, t, L, tmo_step, t, fin);
            if (fin) break;
            t += DLY; m_set(t, 1'b0, 1'b1); stim = t;
            t += DLY; m_set(t, 1'b0, 1'b0);
            do_wait(4, stim, L, tmo_step, t, fin);
            seq_end.push_back(t);
        end
        m_set(t, 1'b0, 1'b0);
        for (int i = t; i < MAXT; i++) begin
            e_st[i] = 1'b0; e_se[i] = 1'b0; e_bz[i] = 1'b0; e_dn[i] = 1'b0;
        end
        if (!fin) e_dn[t] = 1'b1;
        m_end = t;
    endtask

    task automatic truncate(input int at);
        for (int i = at; i < MAXT; i++) begin
            e_st[i] = 1'b0; e_se[i] = 1'b0; e_bz[i] = 1'b0; e_dn[i] = 1'b0;
        end
    endtask

    // Pulses go, then compares the trace cycle by cycle; *_at are edge offsets (-1 = unused)
    task automatic run_trace(input string tag, input int abort_at, input int rst_at,
                             input int go_busy_at, input int stuck_w);
        int loop_drop, sw;
        loop_drop = (seq_end.size() > 1) ? seq_end[seq_end.size() - 2] : -1;
        sw = (stuck_w == 1) ? 0 : ((stuck_w > 1) ? wexit[stuck_w - 1] : -1);
        bus.loop = (seq_end.size() > 1);
        @(negedge clk); bus.go = 1'b1;
        @(negedge clk); bus.go = 1'b0;
        for (int k = 0; k <= m_end + 3; k++) begin
            if (k == 0) begin
                checks++;
                if ({bus.err, bus.err_step, bus.cycles} !== '0) begin
                    failures++;
                    $display("FAIL %s go_clear got err=%b step=%0d cycles=%0d exp 0/0/0",
                             tag, bus.err, bus.err_step, bus.cycles);
                end
            end
            checks += 4;
            if (bus.Start !== e_st[k]) begin
                failures++; $display("FAIL %s Start k=%0d got %b exp %b", tag, k, bus.Start, e_st[k]);
            end
            if (bus.Sensor !== e_se[k]) begin
                failures++; $display("FAIL %s Sensor k=%0d got %b exp %b", tag, k, bus.Sensor, e_se[k]);
            end
            if (bus.busy !== e_bz[k]) begin
                failures++; $display("FAIL %s busy k=%0d got %b exp %b", tag, k, bus.busy, e_bz[k]);
            end
            if (bus.done !== e_dn[k]) begin
                failures++; $display("FAIL %s done k=%0d got %b exp %b", tag, k, bus.done, e_dn[k]);
            end
            if (k == loop_drop) bus.loop = 1'b0;
            if (k == sw) begin act_stuck = 1'b1; act_val = (stuck_w % 2 == 0); end
            bus.go    = (k == go_busy_at);
            bus.abort = (k + 1 == abort_at);
            rst       = (k + 1 == rst_at);
            @(negedge clk);
        end
        bus.go = 1'b0; bus.abort = 1'b0; bus.loop = 1'b0; rst = 1'b0; act_stuck = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.go = 1'b1; bus.loop = 1'b0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus.Start !== 1'b0)    begin failures++; $display("FAIL reset Start got %b exp 0", bus.Start); end
        if (bus.Sensor !== 1'b0)   begin failures++; $display("FAIL reset Sensor got %b exp 0", bus.Sensor); end
        if (bus.busy !== 1'b0)     begin failures++; $display("FAIL reset busy got %b exp 0", bus.busy); end
        if (bus.done !== 1'b0)     begin failures++; $display("FAIL reset done got %b exp 0", bus.done); end
        if (bus.err !== 1'b0)      begin failures++; $display("FAIL reset err got %b exp 0", bus.err); end
        if (bus.err_step !== 3'd0) begin failures++; $display("FAIL reset err_step got %0d exp 0", bus.err_step); end
        if (bus.cycles !== '0)     begin failures++; $display("FAIL reset cycles got %0d exp 0", bus.cycles); end
        bus.go = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_end_state(input string tag, input bit err_e, input int step_e, input int cyc_e);
        checks += 3;
        if (bus.err !== err_e) begin
            failures++; $display("FAIL %s err got %b exp %b", tag, bus.err, err_e);
        end
        if (bus.err_step !== 3'(step_e)) begin
            failures++; $display("FAIL %s err_step got %0d exp %0d", tag, bus.err_step, step_e);
        end
        if (bus.cycles !== CW'(cyc_e)) begin
            failures++; $display("FAIL %s cycles got %0d exp %0d", tag, bus.cycles, cyc_e);
        end
    endtask

    task automatic test_nominal;
        build(4, 1, 0);
        run_trace("nominal", -1, -1, -1, 0);
        test_end_state("nominal", 1'b0, 0, 1);
    endtask

    task automatic test_timeout;
        int order[4] = '{2, 1, 3, 4};
        foreach (order[i]) begin
            build(int'($urandom_range(0, 6)), 1, order[i]);
            run_trace("timeout", -1, -1, -1, order[i]);
            test_end_state("timeout", 1'b1, order[i], 0);
        end
    endtask

    task automatic test_abort;
        int at;
        // abort while idle must leave the sticky error untouched
        @(negedge clk); bus.abort = 1'b1;
        @(negedge clk); bus.abort = 1'b0;
        @(negedge clk);
        test_end_state("abort_idle", 1'b1, 4, 0);
        build(int'($urandom_range(0, 6)), 1, 2);
        run_trace("abort_tmo", m_end, -1, -1, 2);
        test_end_state("abort_tmo", 1'b0, 0, 0);
        build(int'($urandom_range(0, 6)), 2, 0);
        at = wexit[2] + int'($urandom_range(1, DLY));
        truncate(at);
        run_trace("abort_sens2", at, -1, -1, 0);
        test_end_state("abort_sens2", 1'b0, 0, 1);
    endtask

    task automatic test_loop;
        build(int'($urandom_range(0, 6)), 3, 0);
        run_trace("loop", -1, -1, 3, 0);
        test_end_state("loop", 1'b0, 0, 3);
    endtask

    task automatic test_reset_mid;
        int L, at;
        L = int'($urandom_range(0, 6));
        build(L, 2, 0);
        at = wentry[3] + int'($urandom_range(1, L + 3));
        truncate(at);
        run_trace("reset_mid", -1, at, 2, 0);
        test_end_state("reset_mid", 1'b0, 0, 0);
    endtask

    task automatic test_saturation;
        build(int'($urandom_range(0, 6)), 5, 0);
        run_trace("saturate", -1, -1, -1, 0);
        test_end_state("saturate", 1'b0, 0, 3);
    endtask

    task automatic test_back_to_back;
        int n;
        repeat (3) begin
            n = int'($urandom_range(1, 2));
            build(int'($urandom_range(0, 6)), n, 0);
            run_trace("b2b", -1, -1, -1, 0);
            test_end_state("b2b", 1'b0, 0, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.go = 1'b0; bus.loop = 1'b0; bus.abort = 1'b0;
        test_reset();
        test_nominal();
        test_timeout();
        test_abort();
        test_loop();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
